// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - encodings, state type and control word for the multicycle MIPS controller
// Contents: opcode constants, ALUOp / alu_src_b / pc_src select codes,
// the 4-bit state enum ctrl_state_t, the packed control word ctrl_word_t
// and an opcode legality helper shared by the top level.
package mips_ctrl_pkg;

    // Supported opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALUOp codes; must match the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } ctrl_state_t;

    // Moore control word. pc_write and branch are internal terms that the
    // top level folds into pc_en.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_word_t;

    function automatic logic opcode_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// rtl/mips_ctrl_outdec.sv - combinational state to control word decoder
// Ports:
//   state : current controller state
//   cw    : control word for that state (all fields 0 unless set below)
// FETCH reports ir_write/pc_write as 1; the top level qualifies them with
// mem_ready so they fire only in the completing fetch cycle.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  ctrl_state_t state,
    output ctrl_word_t  cw
);

    always_comb begin
        cw = '0;
        unique case (state)
            S_FETCH: begin
                cw.mem_req   = 1'b1;
                cw.ir_write  = 1'b1;
                cw.pc_write  = 1'b1;
                cw.iord      = 1'b0;
                cw.alu_src_a = 1'b0;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.pc_src    = PCSRC_ALU;
            end
            S_DECODE: begin
                // branch target precompute: PC + (SignImm << 2)
                cw.alu_src_a = 1'b0;
                cw.alu_src_b = SRCB_IMM_SL2;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                cw.mem_req = 1'b1;
                cw.iord    = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_dst    = 1'b0;
                cw.mem_to_reg = 1'b1;
                cw.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_req   = 1'b1;
                cw.mem_write = 1'b1;
                cw.iord      = 1'b1;
            end
            S_EXECUTE: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_dst    = 1'b1;
                cw.mem_to_reg = 1'b0;
                cw.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_B;
                cw.alu_op    = ALUOP_SUB;
                cw.pc_src    = PCSRC_ALUOUT;
                cw.branch    = 1'b1;
            end
            S_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                cw.reg_dst    = 1'b0;
                cw.mem_to_reg = 1'b0;
                cw.reg_write  = 1'b1;
            end
            S_JUMP: begin
                cw.pc_src   = PCSRC_JUMP;
                cw.pc_write = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - main control FSM of the multicycle MIPS datapath
// Inputs : clk, reset_n (async active-low), opcode (instr[31:26]), zero (ALU flag),
//          mem_ready (memory completes current access this cycle)
// Outputs: mem_req, mem_write, ir_write, pc_en, iord, alu_src_a, alu_src_b[1:0],
//          alu_op[1:0], pc_src[1:0], reg_dst, mem_to_reg, reg_write, illegal_op
// Holds the state register and next-state logic; per-state outputs come from
// mips_ctrl_outdec. Enables are gated low while reset_n is asserted.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_en,
    output logic       iord,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal_op
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    ctrl_word_t  cw;
    logic        in_fetch;
    logic        pc_write;

    mips_ctrl_outdec u_outdec (
        .state (state),
        .cw    (cw)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
                    default:      state_next = S_FETCH;
                endcase
            end
            // opcode is still lw or sw here; anything else is unreachable
            S_MEMADR:  state_next = (opcode == OP_LW) ? S_MEMRD :
                                    (opcode == OP_SW) ? S_MEMWR : S_FETCH;
            S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_next = S_ALUWB;
            S_ALUWB:   state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_ADDIEX:  state_next = S_ADDIWB;
            S_ADDIWB:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // The fetch strobes fire only in the completing fetch cycle; JUMP's
    // pc_write is unconditional.
    assign in_fetch = (state == S_FETCH);
    assign pc_write = cw.pc_write & (~in_fetch | mem_ready);

    // Mux selects need no gating: reset holds the state at FETCH.
    assign iord       = cw.iord;
    assign alu_src_a  = cw.alu_src_a;
    assign alu_src_b  = cw.alu_src_b;
    assign alu_op     = cw.alu_op;
    assign pc_src     = cw.pc_src;
    assign reg_dst    = cw.reg_dst;
    assign mem_to_reg = cw.mem_to_reg;

    assign mem_req    = reset_n & cw.mem_req;
    assign mem_write  = reset_n & cw.mem_write;
    assign ir_write   = reset_n & cw.ir_write & (~in_fetch | mem_ready);
    assign pc_en      = reset_n & (pc_write | (cw.branch & zero));
    assign reg_write  = reset_n & cw.reg_write;
    assign illegal_op = reset_n & (state == S_DECODE) & ~opcode_supported(opcode);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - scoreboard bench for mips_multicycle_control
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, ir_write, pc_en, iord, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       reg_dst, mem_to_reg, reg_write, illegal_op;

    mips_multicycle_control dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .iord       (iord),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector, MSB first: mem_req mem_write ir_write pc_en iord alu_src_a
    // alu_src_b[2] alu_op[2] pc_src[2] reg_dst mem_to_reg reg_write illegal_op
    logic [15:0] act;
    assign act = {mem_req, mem_write, ir_write, pc_en, iord, alu_src_a,
                  alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, reg_write, illegal_op};

    localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                   P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9,
                   P_ADDIEX = 10, P_ADDIWB = 11, P_JUMP = 12;

    typedef struct {
        logic [15:0] v;
        int          ph;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic string pname(input int ph);
        case (ph)
            P_RST:    return "reset";
            P_FETCH:  return "fetch";
            P_DECODE: return "decode";
            P_MEMADR: return "memadr";
            P_MEMRD:  return "memrd";
            P_MEMWB:  return "memwb";
            P_MEMWR:  return "memwr";
            P_EXEC:   return "execute";
            P_ALUWB:  return "aluwb";
            P_BRANCH: return "branch";
            P_ADDIEX: return "addiex";
            P_ADDIWB: return "addiwb";
            P_JUMP:   return "jump";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Reference: expected outputs of one cycle of a given instruction step
    function automatic logic [15:0] exp_vec(input int ph, input logic mr,
                                            input logic z, input logic ill);
        logic mreq = 0, mwr = 0, irw = 0, pcen = 0, io = 0, sa = 0;
        logic [1:0] sb = 2'b00, aop = 2'b00, ps = 2'b00;
        logic rd = 0, m2r = 0, rw = 0, il = 0;
        case (ph)
            P_RST:    sb = 2'b01;
            P_FETCH:  begin mreq = 1; irw = mr; pcen = mr; sb = 2'b01; end
            P_DECODE: begin sb = 2'b11; il = ill; end
            P_MEMADR: begin sa = 1; sb = 2'b10; end
            P_MEMRD:  begin mreq = 1; io = 1; end
            P_MEMWB:  begin m2r = 1; rw = 1; end
            P_MEMWR:  begin mreq = 1; mwr = 1; io = 1; end
            P_EXEC:   begin sa = 1; aop = 2'b10; end
            P_ALUWB:  begin rd = 1; rw = 1; end
            P_BRANCH: begin sa = 1; aop = 2'b01; ps = 2'b01; pcen = z; end
            P_ADDIEX: begin sa = 1; sb = 2'b10; end
            P_ADDIWB: rw = 1;
            P_JUMP:   begin ps = 2'b10; pcen = 1; end
            default:  ;
        endcase
        return {mreq, mwr, irw, pcen, io, sa, sb, aop, ps, rd, m2r, rw, il};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", name, got, want);
        end
    endtask

    // Monitor: one expected vector per cycle, compared mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t it;
            it = q.pop_front();
            check(pname(it.ph), act, it.v);
        end
    end

    // Called at posedge+1: drive this cycle's inputs, record expectation, advance
    task automatic step(input int ph, input logic mr, input logic z, input logic ill);
        exp_t it;
        mem_ready = mr;
        zero      = z;
        it.v  = exp_vec(ph, mr, z, ill);
        it.ph = ph;
        q.push_back(it);
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic bz);
        opcode = op;
        for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, rb(), 1'b0);
        step(P_FETCH, 1'b1, rb(), 1'b0);
        step(P_DECODE, rb(), rb(), !is_legal(op));
        case (op)
            6'b100011: begin
                step(P_MEMADR, rb(), rb(), 1'b0);
                for (int i = 0; i < mw; i++) step(P_MEMRD, 1'b0, rb(), 1'b0);
                step(P_MEMRD, 1'b1, rb(), 1'b0);
                step(P_MEMWB, rb(), rb(), 1'b0);
            end
            6'b101011: begin
                step(P_MEMADR, rb(), rb(), 1'b0);
                for (int i = 0; i < mw; i++) step(P_MEMWR, 1'b0, rb(), 1'b0);
                step(P_MEMWR, 1'b1, rb(), 1'b0);
            end
            6'b000000: begin
                step(P_EXEC, rb(), rb(), 1'b0);
                step(P_ALUWB, rb(), rb(), 1'b0);
            end
            6'b000100: step(P_BRANCH, rb(), bz, 1'b0);
            6'b001000: begin
                step(P_ADDIEX, rb(), rb(), 1'b0);
                step(P_ADDIWB, rb(), rb(), 1'b0);
            end
            6'b000010: step(P_JUMP, rb(), rb(), 1'b0);
            default: ;
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        exp_t it;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

        reset_n   = 1'b0;
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        zero      = 1'b0;
        @(posedge clk);
        #1;
        step(P_RST, 1'b1, 1'b0, 1'b0);
        step(P_RST, 1'b1, 1'b1, 1'b0);
        reset_n = 1'b1;

        // directed cases
        run_instr(6'b100011, 0, 0, 1'b0);   // lw, 5 cycles
        run_instr(6'b000000, 0, 0, 1'b0);   // R-type
        run_instr(6'b000100, 0, 0, 1'b1);   // beq taken
        run_instr(6'b000100, 0, 0, 1'b0);   // beq not taken
        run_instr(6'b101011, 0, 3, 1'b0);   // sw with 3 wait cycles
        run_instr(6'b111111, 0, 0, 1'b0);   // illegal
        run_instr(6'b001000, 1, 0, 1'b0);   // addi with fetch wait
        run_instr(6'b000010, 0, 0, 1'b0);   // j

        // asynchronous reset while waiting in MEMRD
        opcode = 6'b100011;
        step(P_FETCH, 1'b1, 1'b0, 1'b0);
        step(P_DECODE, 1'b1, 1'b0, 1'b0);
        step(P_MEMADR, 1'b1, 1'b0, 1'b0);
        mem_ready = 1'b0;
        it.v  = exp_vec(P_MEMRD, 1'b0, 1'b0, 1'b0);
        it.ph = P_MEMRD;
        q.push_back(it);
        #6;
        reset_n = 1'b0;
        #1;
        check("async_reset", act, exp_vec(P_RST, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        step(P_RST, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        run_instr(6'b100011, 0, 1, 1'b0);   // restarts at FETCH

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k < 6) begin
                op = ops[k];
            end else begin
                op = 6'($urandom_range(0, 63));
                while (is_legal(op)) op = 6'($urandom_range(0, 63));
            end
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
        end

        #10;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
